// File: rtl/traffic_light_sequencer_pkg.sv
// Shared phase encoding, status-display codes and reload-value helper for the
// traffic light sequencer.
package traffic_pkg;

  typedef enum logic [1:0] {
    PhGreen  = 2'd0,
    PhYellow = 2'd1,
    PhAllRed = 2'd2,
    PhFlash  = 2'd3
  } phase_t;

  localparam logic [7:0] SEG_GREEN     = 8'b0111_0111;
  localparam logic [7:0] SEG_YELLOW    = 8'b0111_0110;
  localparam logic [7:0] SEG_ALL_RED   = 8'b0000_1110;
  localparam logic [7:0] SEG_FLASH_ON  = 8'b0111_0001;
  localparam logic [7:0] SEG_FLASH_OFF = 8'b0000_0000;

  // Counter reload value (duration - 1) for a phase; the caller truncates to
  // its counter width. ped selects the extended green.
  function automatic int unsigned dur_m1(input phase_t      ph,
                                         input logic        ped,
                                         input int unsigned green,
                                         input int unsigned ped_extra,
                                         input int unsigned yellow,
                                         input int unsigned allred,
                                         input int unsigned flash);
    int unsigned dur;
    unique case (ph)
      PhGreen:  dur = ped ? green + ped_extra : green;
      PhYellow: dur = yellow;
      PhAllRed: dur = allred;
      PhFlash:  dur = flash;
      default:  dur = 1;
    endcase
    return dur - 1;
  endfunction

endpackage

// File: rtl/traffic_light_sequencer_if.sv
// Controller-side bundle: timebase/request inputs and lamp/display outputs.
interface traffic_light_sequencer_if #(
  parameter int unsigned NUM_DIRS = 2
);
  import traffic_pkg::*;

  logic                tick_en;
  logic [NUM_DIRS-1:0] ped_req;
  logic                flash_mode;
  logic [NUM_DIRS-1:0] light_g;
  logic [NUM_DIRS-1:0] light_y;
  logic [NUM_DIRS-1:0] light_r;
  logic [1:0]          active_dir;
  logic                ped_walk;
  logic [7:0]          seg;

  modport master (
    output tick_en, ped_req, flash_mode,
    input  light_g, light_y, light_r, active_dir, ped_walk, seg
  );

  modport slave (
    input  tick_en, ped_req, flash_mode,
    output light_g, light_y, light_r, active_dir, ped_walk, seg
  );

endinterface

// File: rtl/traffic_light_sequencer_phase_timer.sv
// Loadable down-counter that steps on timebase strobes and flags the strobe
// that arrives while it already reads zero.
module phase_timer #(
  parameter int unsigned           CNT_W     = 8,
  parameter logic [CNT_W-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick_en,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RESET_VAL;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick_en && count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign count  = count_q;
  assign expire = tick_en & (count_q == '0);

endmodule

// File: rtl/traffic_light_sequencer.sv
// Round-robin intersection controller: green/yellow/all-red per approach, latched
// pedestrian walk with green extension, and a flashing-yellow night mode.
module traffic_light_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_DIRS        = 2,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned GREEN_TICKS     = 20,
  parameter int unsigned PED_EXTRA_TICKS = 10,
  parameter int unsigned YELLOW_TICKS    = 4,
  parameter int unsigned ALLRED_TICKS    = 2,
  parameter int unsigned FLASH_TICKS     = 5
) (
  input logic                        clk,
  input logic                        reset,
  traffic_light_sequencer_if.slave   bus
);

  localparam longint unsigned CntRange = 64'd1 << CNT_W;

  if (NUM_DIRS < 2 || NUM_DIRS > 4 ||
      GREEN_TICKS < 1 || YELLOW_TICKS < 1 || ALLRED_TICKS < 1 || FLASH_TICKS < 1 ||
      64'(GREEN_TICKS) + 64'(PED_EXTRA_TICKS) > CntRange ||
      64'(YELLOW_TICKS) > CntRange || 64'(ALLRED_TICKS) > CntRange ||
      64'(FLASH_TICKS) > CntRange) begin : g_bad_params
    $error("traffic_light_sequencer: parameter out of range");
  end

  function automatic logic [CNT_W-1:0] to_cnt(input int unsigned v);
    return CNT_W'(v);
  endfunction

  localparam logic [CNT_W-1:0] LdGreen    = to_cnt(dur_m1(PhGreen, 1'b0, GREEN_TICKS,
      PED_EXTRA_TICKS, YELLOW_TICKS, ALLRED_TICKS, FLASH_TICKS));
  localparam logic [CNT_W-1:0] LdGreenPed = to_cnt(dur_m1(PhGreen, 1'b1, GREEN_TICKS,
      PED_EXTRA_TICKS, YELLOW_TICKS, ALLRED_TICKS, FLASH_TICKS));
  localparam logic [CNT_W-1:0] LdYellow   = to_cnt(dur_m1(PhYellow, 1'b0, GREEN_TICKS,
      PED_EXTRA_TICKS, YELLOW_TICKS, ALLRED_TICKS, FLASH_TICKS));
  localparam logic [CNT_W-1:0] LdAllRed   = to_cnt(dur_m1(PhAllRed, 1'b0, GREEN_TICKS,
      PED_EXTRA_TICKS, YELLOW_TICKS, ALLRED_TICKS, FLASH_TICKS));
  localparam logic [CNT_W-1:0] LdFlash    = to_cnt(dur_m1(PhFlash, 1'b0, GREEN_TICKS,
      PED_EXTRA_TICKS, YELLOW_TICKS, ALLRED_TICKS, FLASH_TICKS));

  phase_t              phase_q, phase_d;
  logic [1:0]          dir_q, dir_d, next_dir;
  logic [NUM_DIRS-1:0] pending_q, pending_d, req_all, dir_oh, next_oh;
  logic                walk_q, walk_d;
  logic                flash_lit_q, flash_lit_d;
  logic                restart_q, restart_d;

  logic                tmr_load, tmr_expire;
  logic [CNT_W-1:0]    tmr_val, tmr_count;

  // One timer serves every phase, including the flash half-period.
  phase_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (LdAllRed)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick_en  (bus.tick_en),
    .count    (tmr_count),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q     <= PhAllRed;
      dir_q       <= '0;
      pending_q   <= '0;
      walk_q      <= 1'b0;
      flash_lit_q <= 1'b0;
      restart_q   <= 1'b1;
    end else begin
      phase_q     <= phase_d;
      dir_q       <= dir_d;
      pending_q   <= pending_d;
      walk_q      <= walk_d;
      flash_lit_q <= flash_lit_d;
      restart_q   <= restart_d;
    end
  end

  // restart_q forces the next green back to direction 0 (after reset or night mode).
  always_comb begin
    next_dir = (restart_q || dir_q == 2'(NUM_DIRS - 1)) ? 2'd0 : dir_q + 2'd1;
    next_oh  = NUM_DIRS'(1) << next_dir;
    dir_oh   = NUM_DIRS'(1) << dir_q;
    req_all  = pending_q | bus.ped_req;
  end

  always_comb begin
    phase_d     = phase_q;
    dir_d       = dir_q;
    pending_d   = req_all;
    walk_d      = walk_q;
    flash_lit_d = flash_lit_q;
    restart_d   = restart_q;
    tmr_load    = 1'b0;
    tmr_val     = LdAllRed;
    unique case (phase_q)
      PhGreen: begin
        if (bus.flash_mode || tmr_expire) begin
          phase_d  = PhYellow;
          walk_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = LdYellow;
        end
      end
      PhYellow: begin
        if (tmr_expire) begin
          phase_d  = PhAllRed;
          tmr_load = 1'b1;
          tmr_val  = LdAllRed;
        end
      end
      PhAllRed: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (bus.flash_mode) begin
            phase_d     = PhFlash;
            flash_lit_d = 1'b1;
            tmr_val     = LdFlash;
          end else begin
            phase_d   = PhGreen;
            dir_d     = next_dir;
            restart_d = 1'b0;
            walk_d    = |(req_all & next_oh);
            pending_d = req_all & ~next_oh;
            tmr_val   = walk_d ? LdGreenPed : LdGreen;
          end
        end
      end
      PhFlash: begin
        if (!bus.flash_mode) begin
          phase_d   = PhAllRed;
          restart_d = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = LdAllRed;
        end else if (tmr_expire) begin
          flash_lit_d = ~flash_lit_q;
          tmr_load    = 1'b1;
          tmr_val     = LdFlash;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.light_g  = '0;
    bus.light_y  = '0;
    bus.light_r  = '1;
    bus.ped_walk = 1'b0;
    bus.seg      = SEG_ALL_RED;
    unique case (phase_q)
      PhGreen: begin
        bus.light_g  = dir_oh;
        bus.light_r  = ~dir_oh;
        bus.ped_walk = walk_q;
        bus.seg      = SEG_GREEN;
      end
      PhYellow: begin
        bus.light_y = dir_oh;
        bus.light_r = ~dir_oh;
        bus.seg     = SEG_YELLOW;
      end
      PhAllRed: ;
      PhFlash: begin
        bus.light_r = '0;
        bus.light_y = {NUM_DIRS{flash_lit_q}};
        bus.seg     = flash_lit_q ? SEG_FLASH_ON : SEG_FLASH_OFF;
      end
      default: ;
    endcase
  end

  assign bus.active_dir = dir_q;

  // A green without walk never holds more than its own reload value.
  always_ff @(posedge clk) begin
    if (!reset && phase_q == PhGreen && !walk_q) begin
      assert (tmr_count <= LdGreen);
    end
  end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer: phase timing, strobe spacing,
// pedestrian walk, night flash, async reset and 4-way rotation.
module tb_traffic_light_sequencer;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   tick_period = 1;
  int   tick_cnt = 0;

  always #5 clk = ~clk;

  traffic_light_sequencer_if #(.NUM_DIRS(2)) bus2 ();
  traffic_light_sequencer_if #(.NUM_DIRS(4)) bus4 ();

  traffic_light_sequencer #(.NUM_DIRS(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  traffic_light_sequencer #(.NUM_DIRS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  // Timebase strobe: one clk high every tick_period clks.
  always @(posedge clk) begin
    #1;
    if (tick_period <= 1) tick_cnt = 0;
    else tick_cnt = (tick_cnt + 1) % tick_period;
    bus2.tick_en = (tick_cnt == 0);
    bus4.tick_en = (tick_cnt == 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Steps until seg changes; n = clks spent (-1 on timeout). stable drops if any
  // lamp/walk/dir output moved while seg held.
  task automatic run_phase(output int n, output bit stable);
    logic [7:0] s0;
    logic [8:0] snap;
    s0 = bus2.seg;
    snap = {bus2.light_g, bus2.light_y, bus2.light_r, bus2.ped_walk, bus2.active_dir};
    n = 0;
    stable = 1'b1;
    while (bus2.seg === s0 && n < 1000) begin
      step();
      n++;
      if (bus2.seg === s0 &&
          {bus2.light_g, bus2.light_y, bus2.light_r, bus2.ped_walk, bus2.active_dir} !== snap)
        stable = 1'b0;
    end
    if (n >= 1000) n = -1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus2.light_r !== 2'b11) begin errors++;
      $display("FAIL reset_red: got %b expected 11", bus2.light_r); end
    checks++; if ({bus2.light_g, bus2.light_y} !== 4'b0000) begin errors++;
      $display("FAIL reset_gy: got %b expected 0000", {bus2.light_g, bus2.light_y}); end
    checks++; if (bus2.ped_walk !== 1'b0) begin errors++;
      $display("FAIL reset_walk: got %b expected 0", bus2.ped_walk); end
    checks++; if (bus2.seg !== 8'h0E) begin errors++;
      $display("FAIL reset_seg: got %h expected 0e", bus2.seg); end
    checks++; if (bus2.active_dir !== 2'd0) begin errors++;
      $display("FAIL reset_dir: got %0d expected 0", bus2.active_dir); end
  endtask

  task automatic test_sequence();
    int n;
    bit st;
    tick_period = 1;
    do_reset();
    run_phase(n, st);
    checks++; if (n !== 2) begin errors++;
      $display("FAIL seq_allred0_len: got %0d expected 2", n); end
    checks++; if (bus2.seg !== 8'h77 || bus2.active_dir !== 2'd0 || bus2.light_g !== 2'b01 ||
                  bus2.light_r !== 2'b10) begin errors++;
      $display("FAIL seq_green0: seg %h dir %0d g %b r %b expected 77 0 01 10",
               bus2.seg, bus2.active_dir, bus2.light_g, bus2.light_r); end
    run_phase(n, st);
    checks++; if (n !== 20) begin errors++;
      $display("FAIL seq_green0_len: got %0d expected 20", n); end
    checks++; if (bus2.seg !== 8'h76 || bus2.light_y !== 2'b01 || bus2.light_r !== 2'b10)
      begin errors++;
      $display("FAIL seq_yellow0: seg %h y %b r %b expected 76 01 10",
               bus2.seg, bus2.light_y, bus2.light_r); end
    run_phase(n, st);
    checks++; if (n !== 4) begin errors++;
      $display("FAIL seq_yellow_len: got %0d expected 4", n); end
    checks++; if (bus2.seg !== 8'h0E || bus2.light_r !== 2'b11) begin errors++;
      $display("FAIL seq_allred: seg %h r %b expected 0e 11", bus2.seg, bus2.light_r); end
    run_phase(n, st);
    checks++; if (n !== 2) begin errors++;
      $display("FAIL seq_allred_len: got %0d expected 2", n); end
    checks++; if (bus2.seg !== 8'h77 || bus2.active_dir !== 2'd1 || bus2.light_g !== 2'b10)
      begin errors++;
      $display("FAIL seq_green1: seg %h dir %0d g %b expected 77 1 10",
               bus2.seg, bus2.active_dir, bus2.light_g); end
  endtask

  task automatic test_slow_tick();
    int n;
    bit st;
    tick_period = 4;
    do_reset();
    run_phase(n, st);
    run_phase(n, st);
    checks++; if (n !== 80 || !st) begin errors++;
      $display("FAIL slow_green_len: got %0d stable %0b expected 80 1", n, st); end
    run_phase(n, st);
    checks++; if (n !== 16 || !st) begin errors++;
      $display("FAIL slow_yellow_len: got %0d stable %0b expected 16 1", n, st); end
    run_phase(n, st);
    checks++; if (n !== 8 || !st) begin errors++;
      $display("FAIL slow_allred_len: got %0d stable %0b expected 8 1", n, st); end
    checks++; if (bus2.active_dir !== 2'd1 || bus2.seg !== 8'h77) begin errors++;
      $display("FAIL slow_green1: dir %0d seg %h expected 1 77", bus2.active_dir, bus2.seg); end
    tick_period = 1;
  endtask

  task automatic test_ped_walk();
    int n;
    bit st;
    tick_period = 1;
    do_reset();
    run_phase(n, st);
    repeat (3) step();
    bus2.ped_req = 2'b10;
    step();
    bus2.ped_req = 2'b00;
    checks++; if (bus2.ped_walk !== 1'b0) begin errors++;
      $display("FAIL ped_dir0_walk: got %b expected 0", bus2.ped_walk); end
    run_phase(n, st);
    checks++; if (n !== 16) begin errors++;
      $display("FAIL ped_green0_rest: got %0d expected 16", n); end
    run_phase(n, st);
    run_phase(n, st);
    checks++; if (bus2.active_dir !== 2'd1 || bus2.ped_walk !== 1'b1) begin errors++;
      $display("FAIL ped_green1_walk: dir %0d walk %b expected 1 1",
               bus2.active_dir, bus2.ped_walk); end
    run_phase(n, st);
    checks++; if (n !== 30 || !st) begin errors++;
      $display("FAIL ped_green1_len: got %0d stable %0b expected 30 1", n, st); end
    checks++; if (bus2.ped_walk !== 1'b0 || bus2.seg !== 8'h76) begin errors++;
      $display("FAIL ped_yellow_walk: walk %b seg %h expected 0 76", bus2.ped_walk, bus2.seg); end
    repeat (5) run_phase(n, st);
    checks++; if (bus2.active_dir !== 2'd1 || bus2.ped_walk !== 1'b0) begin errors++;
      $display("FAIL ped_green1_again: dir %0d walk %b expected 1 0",
               bus2.active_dir, bus2.ped_walk); end
    run_phase(n, st);
    checks++; if (n !== 20) begin errors++;
      $display("FAIL ped_green1_again_len: got %0d expected 20", n); end
  endtask

  task automatic test_flash();
    int n;
    bit st;
    tick_period = 1;
    do_reset();
    run_phase(n, st);
    repeat (5) step();
    bus2.flash_mode = 1'b1;
    step();
    checks++; if (bus2.seg !== 8'h76) begin errors++;
      $display("FAIL flash_forced_yellow: seg %h expected 76", bus2.seg); end
    run_phase(n, st);
    checks++; if (n !== 4) begin errors++;
      $display("FAIL flash_yellow_len: got %0d expected 4", n); end
    run_phase(n, st);
    checks++; if (n !== 2) begin errors++;
      $display("FAIL flash_allred_len: got %0d expected 2", n); end
    checks++; if (bus2.seg !== 8'h71 || bus2.light_y !== 2'b11 || bus2.light_g !== 2'b00 ||
                  bus2.light_r !== 2'b00 || bus2.ped_walk !== 1'b0) begin errors++;
      $display("FAIL flash_lit: seg %h y %b g %b r %b walk %b expected 71 11 00 00 0",
               bus2.seg, bus2.light_y, bus2.light_g, bus2.light_r, bus2.ped_walk); end
    run_phase(n, st);
    checks++; if (n !== 5 || bus2.seg !== 8'h00 || bus2.light_y !== 2'b00) begin errors++;
      $display("FAIL flash_dark: len %0d seg %h y %b expected 5 00 00",
               n, bus2.seg, bus2.light_y); end
    run_phase(n, st);
    checks++; if (n !== 5 || bus2.seg !== 8'h71) begin errors++;
      $display("FAIL flash_relit: len %0d seg %h expected 5 71", n, bus2.seg); end
    repeat (2) step();
    bus2.flash_mode = 1'b0;
    step();
    checks++; if (bus2.seg !== 8'h0E || bus2.light_r !== 2'b11) begin errors++;
      $display("FAIL flash_exit_allred: seg %h r %b expected 0e 11", bus2.seg, bus2.light_r); end
    run_phase(n, st);
    checks++; if (n !== 2 || bus2.seg !== 8'h77 || bus2.active_dir !== 2'd0) begin errors++;
      $display("FAIL flash_exit_green0: len %0d seg %h dir %0d expected 2 77 0",
               n, bus2.seg, bus2.active_dir); end
  endtask

  task automatic test_async_reset();
    int n;
    bit st;
    tick_period = 1;
    do_reset();
    run_phase(n, st);
    run_phase(n, st);
    repeat (2) step();
    #3;
    reset = 1'b1;
    #1;
    checks++; if (bus2.light_r !== 2'b11 || bus2.light_g !== 2'b00 || bus2.light_y !== 2'b00 ||
                  bus2.seg !== 8'h0E) begin errors++;
      $display("FAIL async_reset_out: r %b g %b y %b seg %h expected 11 00 00 0e",
               bus2.light_r, bus2.light_g, bus2.light_y, bus2.seg); end
    do_reset();
    run_phase(n, st);
    checks++; if (n !== 2) begin errors++;
      $display("FAIL async_restart_allred: got %0d expected 2", n); end
    run_phase(n, st);
    checks++; if (n !== 20) begin errors++;
      $display("FAIL async_restart_green: got %0d expected 20", n); end
  endtask

  task automatic test_four_dirs();
    int         seq[$];
    int         bad = 0;
    logic [7:0] prev;
    tick_period = 1;
    do_reset();
    prev = bus4.seg;
    for (int i = 0; i < 112; i++) begin
      step();
      if (bus4.seg === 8'h77 && prev !== 8'h77) seq.push_back(int'(bus4.active_dir));
      if (bus4.seg === 8'h77 || bus4.seg === 8'h76) begin
        if ($countones(~bus4.light_r) != 1 || (bus4.light_g | bus4.light_y) !== ~bus4.light_r)
          bad++;
      end else if (bus4.light_r !== 4'b1111) begin
        bad++;
      end
      prev = bus4.seg;
    end
    checks++; if (seq.size() != 5) begin errors++;
      $display("FAIL four_green_count: got %0d expected 5", seq.size()); end
    for (int k = 0; k < seq.size() && k < 5; k++) begin
      checks++; if (seq[k] != k % 4) begin errors++;
        $display("FAIL four_dir_order[%0d]: got %0d expected %0d", k, seq[k], k % 4); end
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL four_one_non_red: got %0d bad cycles expected 0", bad); end
  endtask

  initial begin
    bus2.ped_req    = '0;
    bus2.flash_mode = 1'b0;
    bus4.ped_req    = '0;
    bus4.flash_mode = 1'b0;
    test_reset();
    test_sequence();
    test_slow_tick();
    test_ped_walk();
    test_flash();
    test_async_reset();
    test_four_dirs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
